core_sequencer: RTL and testbench
=================================

# core_sequencer

Per-core control FSM that drives the 3-bit `core_state` bus consumed by the fetcher, decoder, per-thread LSUs, ALUs and PC units. It steps one instruction at a time through FETCH, DECODE, REQUEST, WAIT, EXECUTE and UPDATE. It holds the shared program counter for the block's threads and raises `done` when a RET instruction retires. One instance sits in each core, next to the decoder.

## Interface
One clock; reset is synchronous and active-low.

Parameters:
- THREADS_PER_BLOCK, 4: number of thread lanes (LSU/PC units) in the core.
- PC_BITS, 8: program counter width.
- WAIT_TIMEOUT, 255: maximum WAIT-state cycles before abort. Used only with the watchdog compiled in.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low; the block is in reset while this is 0.
- start  in  1  level; sampled only in IDLE.
- thread_enable  in  THREADS_PER_BLOCK  lane active mask; must be stable from `start` until `done`.
- fetcher_state  in  3  fetcher status; 3'b010 = FETCHED.
- lsu_state  in  2*THREADS_PER_BLOCK  per-lane LSU status, lane i at [2i+1:2i]; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
- next_pc  in  PC_BITS*THREADS_PER_BLOCK  per-lane next PC from the PC units.
- decoded_ret  in  1  registered decoder output.
- core_state  out  3  current state.
- current_pc  out  PC_BITS  PC of the instruction in flight.
- done  out  1  kernel block finished; sticky until reset.
- error  out  1  watchdog abort; sticky until reset.

## Operation
- State encoding (fixed, shared with the decoder and LSUs): IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- IDLE, start=1, thread_enable≠0: go to FETCH and load current_pc to 0.
- IDLE, start=1, thread_enable=0: go directly to DONE and set done=1.
- FETCH: hold until fetcher_state==FETCHED, then go to DECODE.
- DECODE: 1 cycle, then REQUEST. The decoder latches its control fields in this state.
- REQUEST: 1 cycle, then WAIT. The LSUs sample REQUEST to issue loads and stores.
- WAIT: stay while any enabled lane reports REQUESTING or WAITING. Otherwise go to EXECUTE. Disabled lanes are ignored.
- EXECUTE: 1 cycle, then UPDATE.
- UPDATE, decoded_ret=1: go to DONE and set done=1; current_pc is unchanged.
- UPDATE, decoded_ret=0: load current_pc from the next_pc of the lowest-indexed enabled lane, then go to FETCH. Threads are converged by construction, so divergence is not checked.
- DONE: terminal. `start` is ignored. Only reset leaves this state.
- `start` outside IDLE is ignored. The sequencer does not compute PC arithmetic; any PC wrap comes from the PC units.

## Timing
- Reset values: core_state=000, current_pc=0, done=0, error=0. Reset wins over every other event in the same cycle.
- Reset asserted mid-instruction: IDLE on the next edge. No in-flight state is preserved.
- All outputs are registered. Each state change takes effect on the clock edge after its condition is sampled.
- Minimum instruction latency with no memory access and a FETCHED status already present: 6 cycles (FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE).
- For a memory instruction, WAIT lasts until the last enabled LSU reaches IDLE or DONE. The next cycle is EXECUTE.
- done rises in the cycle core_state enters DONE.

## Configuration
- Macro CORE_SEQ_WATCHDOG_EN.
- Defined: a counter clears on entry to WAIT and increments each cycle spent in WAIT. When it reaches WAIT_TIMEOUT, the FSM goes to DONE with done=1 and error=1. The counter width is $clog2(WAIT_TIMEOUT+1).
- Undefined: no counter is built, error is tied to 0, and WAIT may last indefinitely.

## Structure
- Shared package `core_pkg`:
  - core_state enum (the 3-bit encoding above).
  - LSU state constants.
  - Fetcher FETCHED constant.
  - The decoder and LSUs import the same package.
- One sub-module, `lane_pc_select`: a combinational priority encoder that takes thread_enable and next_pc and returns the lowest-enabled-lane PC and an any_enabled flag.

## Test plan
- Reset held 0 for 3 cycles with start=1: core_state=000, current_pc=0, done=0, error=0 throughout.
- Enable mask 4'b1111, FETCHED returned immediately, instruction ADD with next_pc=1 on all lanes: state sequence 001,010,011,100,101,110,001 with current_pc=1 after UPDATE.
- LDR with lane 2 in WAITING for 7 cycles and the other lanes DONE: WAIT lasts exactly 8 cycles, then EXECUTE.
- Enable mask 4'b1100 with next_pc lanes = {9,9,3,3}: current_pc becomes 9. Lane-0/1 LSUs stuck in WAITING must not stall WAIT.
- decoded_ret=1 in UPDATE: DONE and done=1 on the next cycle. A later start pulse has no effect. Reset returns to IDLE.
- With CORE_SEQ_WATCHDOG_EN and WAIT_TIMEOUT=4, lane 0 held in WAITING: after 4 WAIT cycles, core_state=111, done=1, error=1. Without the macro, error stays 0 and the FSM stays in WAIT.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the core sequencer, decoder, fetcher and LSUs.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_FETCH   = 3'b001,
    ST_DECODE  = 3'b010,
    ST_REQUEST = 3'b011,
    ST_WAIT    = 3'b100,
    ST_EXECUTE = 3'b101,
    ST_UPDATE  = 3'b110,
    ST_DONE    = 3'b111
  } core_state_e;

  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  // An LSU still owns the memory transaction while requesting or waiting.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/lane_pc_select.sv
// Priority encoder: next PC of the lowest-indexed enabled lane.
module lane_pc_select #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic [THREADS_PER_BLOCK-1:0]         thread_enable,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [PC_BITS-1:0]                   lane_pc,
  output logic                                 any_enabled
);

  // Scanning from the top lane down lets the lowest enabled lane win last.
  always_comb begin
    lane_pc     = '0;
    any_enabled = |thread_enable;
    for (int i = THREADS_PER_BLOCK - 1; i >= 0; i--) begin
      if (thread_enable[i]) begin
        lane_pc = next_pc[i*PC_BITS +: PC_BITS];
      end
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Per-core instruction sequencer driving core_state for fetcher, decoder, LSUs, ALUs, PC units.
// Optional WAIT watchdog compiled in with CORE_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | waiting for fetcher to report FETCHED
// DECODE  | decoder latches control fields
// REQUEST | LSUs issue loads/stores
// WAIT    | waiting for enabled LSUs to finish
// EXECUTE | ALUs compute
// UPDATE  | retire: next PC or finish on RET
// DONE    | terminal until reset
module core_sequencer
  import core_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int WAIT_TIMEOUT      = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [THREADS_PER_BLOCK-1:0]         thread_enable,
  input  logic [2:0]                           fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  input  logic                                 decoded_ret,
  output logic [2:0]                           core_state,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic                                 done,
  output logic                                 error
);

  if (WAIT_TIMEOUT < 1) begin : g_bad_timeout
    $error("core_sequencer: WAIT_TIMEOUT must be at least 1");
  end

  core_state_e        state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d, lane_pc;
  logic               done_q, done_d, error_q, error_d;
  logic               any_enabled, lanes_busy, wd_expire;

  lane_pc_select #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK),
    .PC_BITS          (PC_BITS)
  ) u_lane_pc_select (
    .thread_enable(thread_enable),
    .next_pc      (next_pc),
    .lane_pc      (lane_pc),
    .any_enabled  (any_enabled)
  );

  // Disabled lanes never hold the core in WAIT, whatever their LSU reports.
  always_comb begin
    lanes_busy = 1'b0;
    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
      if (thread_enable[i] && lsu_busy(lsu_state[2*i +: 2])) begin
        lanes_busy = 1'b1;
      end
    end
  end

`ifdef CORE_SEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(WAIT_TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if (state_q != ST_WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // The cycle that would take the count to WAIT_TIMEOUT aborts instead.
  assign wd_expire = (state_q == ST_WAIT) && lanes_busy &&
                     (wd_cnt == CNT_W'(WAIT_TIMEOUT - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = any_enabled ? ST_FETCH : ST_DONE;
      ST_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_REQUEST;
      ST_REQUEST: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wd_expire)        state_d = ST_DONE;
        else if (!lanes_busy) state_d = ST_EXECUTE;
      end
      ST_EXECUTE: state_d = ST_UPDATE;
      ST_UPDATE:  state_d = decoded_ret ? ST_DONE : ST_FETCH;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    done_d  = done_q | (state_d == ST_DONE);
    error_d = error_q | wd_expire;
    if (state_q == ST_IDLE && state_d == ST_FETCH) begin
      pc_d = '0;
    end else if (state_q == ST_UPDATE && state_d == ST_FETCH) begin
      pc_d = lane_pc;
    end
  end

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: expected per-cycle trace built from instruction-level rules.
module tb_core_sequencer;

  localparam int NT = 4;
  localparam int PB = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3,
                         S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;
  localparam logic [2:0] FETCHED = 3'b010;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NT-1:0]     thread_enable;
  logic [2:0]        fetcher_state;
  logic [2*NT-1:0]   lsu_state;
  logic [PB*NT-1:0]  next_pc;
  logic              decoded_ret;
  logic [2:0]        core_state;
  logic [PB-1:0]     current_pc;
  logic              done;
  logic              error;

  logic [PB-1:0]     pc_lane [NT];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NT; i++) next_pc[i*PB +: PB] = pc_lane[i];
  end

  core_sequencer #(
    .THREADS_PER_BLOCK(NT),
    .PC_BITS          (PB),
    .WAIT_TIMEOUT     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thread_enable(thread_enable),
    .fetcher_state(fetcher_state),
    .lsu_state    (lsu_state),
    .next_pc      (next_pc),
    .decoded_ret  (decoded_ret),
    .core_state   (core_state),
    .current_pc   (current_pc),
    .done         (done),
    .error        (error)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [PB-1:0] pc;
    logic          d;
    logic          e;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  int    vectors = 0;
  int    miscompares = 0;

  logic [PB-1:0] model_pc;
  logic          model_done;
  logic          model_err;

  // Lowest enabled lane's next PC, found by scanning upward.
  function automatic logic [PB-1:0] model_sel_pc();
    for (int i = 0; i < NT; i++) if (thread_enable[i]) return pc_lane[i];
    return '0;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      if (core_state !== e.st || current_pc !== e.pc || done !== e.d || error !== e.e) begin
        miscompares++;
        $display("FAIL %s: got state=%0d pc=%0d done=%b error=%b, expected state=%0d pc=%0d done=%b error=%b",
                 t, core_state, current_pc, done, error, e.st, e.pc, e.d, e.e);
      end
    end
  end

  task automatic tick(input logic [2:0] st, input string tag);
    @(posedge clk);
    #1;
    exp_q.push_back('{st: st, pc: model_pc, d: model_done, e: model_err});
    tag_q.push_back(tag);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    model_pc = '0; model_done = 1'b0; model_err = 1'b0;
    for (int i = 0; i < cycles; i++) tick(S_IDLE, "reset");
    reset = 1'b1;
  endtask

  task automatic start_block(input logic [NT-1:0] en);
    thread_enable = en;
    start = 1'b1;
    if (en != '0) begin
      model_pc = '0;
      tick(S_FETCH, "start");
    end else begin
      model_done = 1'b1;
      tick(S_DONE, "start_empty");
    end
    start = 1'b0;
  endtask

  // Runs one instruction from FETCH: fetch_hold cycles without FETCHED, then
  // busy_lsu held for the first `stall` WAIT samples, free_lsu afterwards.
  task automatic run_instr(input int fetch_hold, input int stall,
                           input logic [2*NT-1:0] busy_lsu, input logic [2*NT-1:0] free_lsu,
                           input logic ret, input string tag);
    fetcher_state = 3'b000;
    for (int i = 0; i < fetch_hold; i++) tick(S_FETCH, tag);
    fetcher_state = FETCHED;
    tick(S_DECODE, tag);
    fetcher_state = 3'b000;
    tick(S_REQUEST, tag);
    lsu_state   = (stall > 0) ? busy_lsu : free_lsu;
    decoded_ret = ret;
    tick(S_WAIT, tag);
    for (int i = 0; i < stall; i++) tick(S_WAIT, tag);
    lsu_state = free_lsu;
    tick(S_EXECUTE, tag);
    tick(S_UPDATE, tag);
    if (ret) begin
      model_done = 1'b1;
      tick(S_DONE, tag);
    end else begin
      model_pc = model_sel_pc();
      tick(S_FETCH, tag);
    end
    lsu_state   = '0;
    decoded_ret = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; thread_enable = 4'b1111;
    fetcher_state = FETCHED; lsu_state = '0; decoded_ret = 1'b0;
    for (int i = 0; i < NT; i++) pc_lane[i] = 8'd1;

    do_reset(3);

    // ADD, all lanes, next_pc = 1
    start_block(4'b1111);
    run_instr(0, 0, '0, '0, 1'b0, "add");
    chk("add_pc", 32'(current_pc), 32'd1);

    // LDR: lane 2 WAITING for 7 WAIT samples, others DONE
    for (int i = 0; i < NT; i++) pc_lane[i] = 8'd2;
    run_instr(0, 7, 8'b11_10_11_11, 8'hFF, 1'b0, "ldr_wait8");
    chk("ldr_pc", 32'(current_pc), 32'd2);

    // Slow fetcher
    for (int i = 0; i < NT; i++) pc_lane[i] = 8'd5;
    run_instr(3, 2, 8'b01_00_00_00, 8'h00, 1'b0, "fetch_hold");

    // RET retires: DONE, pc held, start ignored
    for (int i = 0; i < NT; i++) pc_lane[i] = 8'd77;
    run_instr(0, 0, '0, '0, 1'b1, "ret");
    chk("ret_done", 32'(done), 32'd1);
    chk("ret_pc", 32'(current_pc), 32'd5);
    start = 1'b1;
    tick(S_DONE, "done_start_ignored");
    tick(S_DONE, "done_start_ignored");
    start = 1'b0;
    do_reset(1);
    tick(S_IDLE, "idle_after_reset");

    // Upper lanes only; disabled lanes stuck WAITING
    pc_lane[0] = 8'd3; pc_lane[1] = 8'd3; pc_lane[2] = 8'd9; pc_lane[3] = 8'd9;
    start_block(4'b1100);
    run_instr(0, 0, '0, 8'b11_11_10_10, 1'b0, "mask_1100");
    chk("mask_pc", 32'(current_pc), 32'd9);

    // Reset mid-instruction, in WAIT
    fetcher_state = FETCHED;
    tick(S_DECODE, "mid_reset");
    tick(S_REQUEST, "mid_reset");
    lsu_state = 8'b10_00_00_00;
    tick(S_WAIT, "mid_reset");
    tick(S_WAIT, "mid_reset");
    do_reset(1);
    lsu_state = '0;
    tick(S_IDLE, "mid_reset_idle");
    chk("mid_reset_pc", 32'(current_pc), 32'd0);

    // Empty mask goes straight to DONE
    start_block(4'b0000);
    tick(S_DONE, "empty_hold");
    do_reset(1);

    // Lane 0 stuck WAITING
    start_block(4'b0001);
    fetcher_state = FETCHED;
    tick(S_DECODE, "watchdog");
    tick(S_REQUEST, "watchdog");
    lsu_state = 8'b00_00_00_10;
    tick(S_WAIT, "watchdog");
`ifdef CORE_SEQ_WATCHDOG_EN
    for (int i = 0; i < 3; i++) tick(S_WAIT, "watchdog");
    model_done = 1'b1; model_err = 1'b1;
    tick(S_DONE, "watchdog_abort");
    tick(S_DONE, "watchdog_abort");
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_state", 32'(core_state), 32'd7);
`else
    for (int i = 0; i < 9; i++) tick(S_WAIT, "no_watchdog");
    chk("nowd_error", 32'(error), 32'd0);
    chk("nowd_state", 32'(core_state), 32'd4);
    lsu_state = 8'b00_00_00_11;
    tick(S_EXECUTE, "no_watchdog");
`endif

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
